// File: rtl/mac_feeder.sv
// mac_feeder: operand sequencer upstream of a multiply-accumulate stage.
//
// Operand pairs from a producer are buffered in a small FIFO. Each pair is
// issued to the MAC with a one-cycle mac_start pulse. The next pair is issued
// only after the MAC has gone busy (mac_ready low) and then finished
// (mac_ready high again). Completed operations are counted against a vector
// length that is latched on vec_go. If the MAC never goes busy, a sticky
// timeout flag is raised.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake; in_ready == !full
//   in_a, in_b            operand pair pushed into the FIFO
//   vec_len, vec_go       vector length, start strobe (honoured in IDLE only)
//   busy                  high whenever the FSM is not in IDLE
//   vec_done              one-cycle pulse when the vector ends
//   done_cnt              operations completed in the current/last vector
//   err                   sticky busy-timeout flag
//   mac_start             one-cycle start pulse to the MAC
//   mac_a, mac_b          operands to the MAC, stable for the whole operation
//   mac_ready             MAC idle/done; low while computing
module mac_feeder #(
  parameter int OPSIZE  = 8,
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int BUSY_TO = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPSIZE-1:0] in_a,
  input  logic [OPSIZE-1:0] in_b,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              vec_go,
  output logic              busy,
  output logic              vec_done,
  output logic [LEN_W-1:0]  done_cnt,
  output logic              err,
  output logic              mac_start,
  output logic [OPSIZE-1:0] mac_a,
  output logic [OPSIZE-1:0] mac_b,
  input  logic              mac_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [OPSIZE-1:0] mem_a [DEPTH];
  logic [OPSIZE-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, fifo_empty;

  // in_ready depends only on the registered count, so a same-cycle pop
  // never opens a slot for the producer.
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;

  // NOTE: storage has no reset; validity is carried entirely by count, and
  // leaving the array unreset lets it map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] done_next;
  logic [TO_W-1:0]  to_cnt;
  logic             accept_go, issue, op_done, timeout, finish;

  assign done_next = done_cnt + 1'b1;
  assign pop       = issue;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    accept_go = 1'b0;
    issue     = 1'b0;
    op_done   = 1'b0;
    timeout   = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vec_go) begin
          accept_go = 1'b1;
          if (vec_len == '0) finish  = 1'b1;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!fifo_empty && mac_ready) begin
          issue   = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!mac_ready) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt == TO_W'(BUSY_TO)) begin
          timeout = 1'b1;
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (mac_ready) begin
          op_done = 1'b1;
          if (done_next == len_q) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      done_cnt  <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      vec_done  <= 1'b0;
      mac_start <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
    end else begin
      vec_done  <= finish;
      mac_start <= issue;
      if (accept_go) begin
        len_q    <= vec_len;
        done_cnt <= '0;
      end else if (op_done) begin
        done_cnt <= done_next;
      end
      if (accept_go)    err <= 1'b0;
      else if (timeout) err <= 1'b1;
      // Counts edges spent in WAIT_BUSY with mac_ready still high.
      if (issue)                         to_cnt <= '0;
      else if (state_q == S_WAIT_BUSY)   to_cnt <= to_cnt + 1'b1;
      if (issue) begin
        mac_a <= mem_a[rd_ptr];
        mac_b <= mem_b[rd_ptr];
      end
    end
  end

endmodule
